counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter.sv | 53 +++++
 tb/tb_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// counter: up-counter with terminal-count strobe and sticky overflow flag.
// Optional feature macro: COUNTER_SATURATE_EN
//   defined   -> count stops at MAX_VALUE when enabled at terminal count
//   undefined -> count wraps to zero when enabled at terminal count
module counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VALUE = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VALUE);

  logic at_max;

  // Terminal-count detection, qualified by enable for the tc strobe
  always_comb begin
    at_max = (count == MAX_CNT);
    tc     = at_max && en;
  end

  // Count register: increment, hold, or terminal behaviour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      if (at_max) begin
`ifdef COUNTER_SATURATE_EN
        count <= MAX_CNT;
`else
        count <= '0;
`endif
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // Sticky overflow: set on any enabled edge at terminal count, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (tc) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_counter.sv
// tb_counter: self-checking bench for counter against a behavioural model.
module tb_counter;

  localparam int W = 4;
`ifdef COUNTER_SATURATE_EN
  localparam int MAXV = 9;
  localparam bit SAT  = 1'b1;
`else
  localparam int MAXV = 15;
  localparam bit SAT  = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] count;
  logic         tc;
  logic         ovf;

  int total;
  int bad;

  // Reference model state
  int m_count;
  bit m_ovf;

  counter #(.WIDTH(W), .MAX_VALUE(MAXV)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .count (count),
    .tc    (tc),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model reaction to one rising edge, given the inputs present at that edge
  task automatic model_edge();
    if (rst) begin
      m_count = 0;
      m_ovf   = 1'b0;
    end else if (en) begin
      if (m_count == MAXV) begin
        m_ovf   = 1'b1;
        m_count = SAT ? MAXV : 0;
      end else begin
        m_count = m_count + 1;
      end
    end
  endtask

  // Advance one rising edge and settle 1 ns after it
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic r, input logic e);
    @(negedge clk);
    rst = r;
    en  = e;
    if (r) begin
      m_count = 0;
      m_ovf   = 1'b0;
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0);
    tick();
    total++;
    if (count !== '0 || ovf !== 1'b0 || tc !== 1'b0) begin
      bad++;
      $display("FAIL reset: count=%0d ovf=%b tc=%b, required 0/0/0", count, ovf, tc);
    end
  endtask

  task automatic test_count();
    logic [W-1:0] exp_c;
    drive(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    exp_c = W'(4 % (MAXV + 1));
    total++;
    if (count !== exp_c) begin
      bad++;
      $display("FAIL count4: count=%0d, required %0d", count, exp_c);
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b0);
    tick();
    total++;
    if (count !== W'(4) || tc !== 1'b0) begin
      bad++;
      $display("FAIL hold: count=%0d tc=%b, required 4/0", count, tc);
    end
  endtask

  task automatic test_reset_wins();
    drive(1'b1, 1'b1);
    #1;
    total++;
    if (count !== '0) begin
      bad++;
      $display("FAIL rst_pre_edge: count=%0d, required 0", count);
    end
    tick();
    total++;
    if (count !== '0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL rst_with_en: count=%0d ovf=%b, required 0/0", count, ovf);
    end
    drive(1'b0, 1'b1);
    tick();
    total++;
    if (count !== W'(1)) begin
      bad++;
      $display("FAIL first_after_rst: count=%0d, required 1", count);
    end
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (count !== W'(4)) begin
      bad++;
      $display("FAIL rst_release4: count=%0d, required 4", count);
    end
  endtask

  task automatic test_terminal();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
`ifdef COUNTER_SATURATE_EN
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (count !== W'(9) || ovf !== 1'b1) begin
      bad++;
      $display("FAIL saturate: count=%0d ovf=%b, required 9/1", count, ovf);
    end
`else
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (count !== W'(15) || tc !== 1'b1 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL at_max: count=%0d tc=%b ovf=%b, required 15/1/0", count, tc, ovf);
    end
    tick();
    total++;
    if (count !== '0 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL wrap: count=%0d ovf=%b, required 0/1", count, ovf);
    end
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (count !== W'(3) || ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: count=%0d ovf=%b, required 3/1", count, ovf);
    end
`endif
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (count !== W'(7)) begin
      bad++;
      $display("FAIL pre_async: count=%0d, required 7", count);
    end
    #2;
    rst = 1'b1;
    m_count = 0;
    m_ovf   = 1'b0;
    #1;
    total++;
    if (count !== '0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: count=%0d ovf=%b, required 0/0", count, ovf);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_c;
    drive(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0));
      tick();
      exp_c = W'(m_count);
      total++;
      if (count !== exp_c || ovf !== m_ovf || tc !== (en && m_count == MAXV)) begin
        bad++;
        $display("FAIL random[%0d]: count=%0d ovf=%b tc=%b, required %0d/%b/%b",
                 i, count, ovf, tc, exp_c, m_ovf, (en && m_count == MAXV));
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    m_count = 0;
    m_ovf   = 1'b0;
    rst     = 1'b1;
    en      = 1'b0;
    test_reset();
    test_count();
    test_hold();
    test_reset_wins();
    test_terminal();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
